// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit.
// Holds the operand width, the funct3 operation encodings and the FSM state type
// used by ex_muldiv and ex_divider.
package muldiv_pkg;

   localparam int XLEN = 32;

   // RV32M funct3 encodings; bit 2 separates the divide group from the multiply group
   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/ex_divider.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per step.
// Latency: XLEN step cycles after load; results hold until the next load. No backpressure:
// the owner sequences load/step.
// Ports: clk, reset (async, active-high), load (capture dividend/divisor), step (advance one bit),
//        dividend, divisor (unsigned magnitudes), quotient, remainder (valid after XLEN steps).
module ex_divider #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            step,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   // quo_reg starts as the dividend and is shifted out MSB-first while quotient bits shift in
   logic [XLEN-1:0] quo_reg;
   logic [XLEN-1:0] rem_reg;
   logic [XLEN-1:0] dsr_reg;
   logic [XLEN:0]   trial;
   logic [XLEN:0]   diff;

   // Partial remainder is always below the divisor, so the shifted trial fits in XLEN+1 bits
   // and a non-negative difference always fits back into XLEN bits.
   assign trial = {rem_reg, quo_reg[XLEN-1]};
   assign diff  = trial - {1'b0, dsr_reg};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         quo_reg <= '0;
         rem_reg <= '0;
         dsr_reg <= '0;
      end else if (load) begin
         quo_reg <= dividend;
         rem_reg <= '0;
         dsr_reg <= divisor;
      end else if (step) begin
         if (!diff[XLEN]) begin
            rem_reg <= diff[XLEN-1:0];
            quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
         end else begin
            // restore: keep the shifted remainder, quotient bit is zero
            rem_reg <= trial[XLEN-1:0];
            quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
         end
      end
   end

   assign quotient  = quo_reg;
   assign remainder = rem_reg;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage RV32M multiply/divide unit: shift-add multiplier inline, restoring divider sub-module.
// Latency: 33 cycles from accepted start to done_out (32 iterations + DONE); divide special cases
// (x/0, signed overflow, or any divide when the divider is not built) finish in 1 cycle.
// Backpressure: stall_out freezes the pipeline while busy; start_in is ignored unless IDLE.
// Ports: clk, reset (async, active-high), start_in/op_in/rs1_in/rs2_in (request), flush_in (kill),
//        stall_out, done_out (1-cycle pulse), result_out (zero unless done_out).
// Build option: define EX_MULDIV_DIV_EN to compile in the divider; otherwise DIV/DIVU/REM/REMU
//        complete in 1 cycle with result 0.
module ex_muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_in,
   input  logic [2:0]      op_in,
   input  logic [XLEN-1:0] rs1_in,
   input  logic [XLEN-1:0] rs2_in,
   input  logic            flush_in,
   output logic            stall_out,
   output logic            done_out,
   output logic [XLEN-1:0] result_out
);

   import muldiv_pkg::*;

   state_t            state;
   state_t            state_nxt;
   logic [4:0]        cnt;
   logic [2:0]        op_q;
   logic [XLEN-1:0]   mcand;
   logic [2*XLEN-1:0] prod;
   logic              neg_q;
   logic              neg_r;
   logic              spec;
   logic [XLEN-1:0]   spec_res;

   logic              accept;
   logic              sgn_a;
   logic              sgn_b;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;
   logic              div_fast;
   logic [XLEN-1:0]   spec_val;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] prod_fin;
   logic [XLEN-1:0]   div_q;
   logic [XLEN-1:0]   div_r;
   logic [XLEN-1:0]   quo_fin;
   logic [XLEN-1:0]   rem_fin;

   assign accept = (state == IDLE) && start_in && !flush_in;

   // Operand signedness per op: rs1 is signed for MULH/MULHSU/DIV/REM, rs2 only for MULH/DIV/REM.
   always_comb begin
      sgn_a = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
      sgn_b = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
      a_mag = (sgn_a && rs1_in[XLEN-1]) ? -rs1_in : rs1_in;
      b_mag = (sgn_b && rs2_in[XLEN-1]) ? -rs2_in : rs2_in;
   end

   // Divide cases that bypass the iterative divider, with their precomputed result.
   // op bit 1 selects remainder (REM/REMU) over quotient (DIV/DIVU).
   always_comb begin
`ifdef EX_MULDIV_DIV_EN
      div_fast = 1'b0;
      spec_val = '0;
      if (rs2_in == '0) begin
         div_fast = 1'b1;
         spec_val = op_in[1] ? rs1_in : '1;
      end else if (((op_in == OP_DIV) || (op_in == OP_REM)) &&
                   (rs1_in == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_in == '1)) begin
         div_fast = 1'b1;
         spec_val = op_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end
`else
      div_fast = 1'b1;
      spec_val = '0;
`endif
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!op_in[2])    state_nxt = MUL;
               else if (div_fast) state_nxt = DONE;
               else              state_nxt = DIV;
            end
         end
         MUL, DIV: begin
            if (flush_in)          state_nxt = IDLE;
            else if (cnt == 5'd31) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- Datapath registers ----------------
   // Shift-add step: add the multiplicand into the high half when the current multiplier
   // bit (prod[0]) is set, then shift the whole product right, carry included.
   assign mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         op_q     <= '0;
         mcand    <= '0;
         prod     <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         spec     <= 1'b0;
         spec_res <= '0;
      end else if (accept) begin
         cnt      <= '0;
         op_q     <= op_in;
         mcand    <= b_mag;
         prod     <= {{XLEN{1'b0}}, a_mag};
         // product and quotient take the XOR of the effective signs; remainder follows rs1
         neg_q    <= (sgn_a && rs1_in[XLEN-1]) ^ (sgn_b && rs2_in[XLEN-1]);
         neg_r    <= sgn_a && rs1_in[XLEN-1];
         spec     <= op_in[2] && div_fast;
         spec_res <= spec_val;
      end else if ((state == MUL) || (state == DIV)) begin
         cnt <= cnt + 5'd1;
         if (state == MUL) prod <= {mul_sum, prod[XLEN-1:1]};
      end
   end

`ifdef EX_MULDIV_DIV_EN
   ex_divider #(.XLEN(XLEN)) u_divider (
      .clk       (clk),
      .reset     (reset),
      .load      (accept && op_in[2] && !div_fast),
      .step      (state == DIV),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (div_q),
      .remainder (div_r)
   );
`else
   assign div_q = '0;
   assign div_r = '0;
`endif

   assign prod_fin = neg_q ? -prod  : prod;
   assign quo_fin  = neg_q ? -div_q : div_q;
   assign rem_fin  = neg_r ? -div_r : div_r;

   // ---------------- FSM: outputs ----------------
   // Gated by reset so the outputs drop the instant reset asserts, even with start_in high.
   always_comb begin
      stall_out  = !reset && (accept || (state == MUL) || (state == DIV));
      done_out   = !reset && (state == DONE) && !flush_in;
      result_out = '0;
      if (done_out) begin
         if (spec) begin
            result_out = spec_res;
         end else begin
            case (op_q)
               OP_MUL:                       result_out = prod_fin[XLEN-1:0];
               OP_MULH, OP_MULHSU, OP_MULHU: result_out = prod_fin[2*XLEN-1:XLEN];
               OP_DIV, OP_DIVU:              result_out = quo_fin;
               default:                      result_out = rem_fin;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vectors, expected results pushed to a scoreboard
// queue at issue time and popped/compared by an independent monitor on done_out.
module tb_ex_muldiv;

`ifdef EX_MULDIV_DIV_EN
   localparam bit DIV_ON = 1'b1;
`else
   localparam bit DIV_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start_in;
   logic [2:0]  op_in;
   logic [31:0] rs1_in;
   logic [31:0] rs2_in;
   logic        flush_in;
   logic        stall_out;
   logic        done_out;
   logic [31:0] result_out;

   typedef struct {
      logic [31:0] res;
      int          cyc;
      int          id;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   n_vec    = 0;
   int   n_bad    = 0;
   int   done_cnt = 0;
   int   vec_id   = 0;

   ex_muldiv #(.XLEN(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_in   (start_in),
      .op_in      (op_in),
      .rs1_in     (rs1_in),
      .rs2_in     (rs2_in),
      .flush_in   (flush_in),
      .stall_out  (stall_out),
      .done_out   (done_out),
      .result_out (result_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops one expectation per done_out pulse and checks value and arrival cycle.
   always @(negedge clk) begin
      if (!reset) begin
         if (done_out) begin
            done_cnt++;
            n_vec++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_done cyc=%0d result=%h required no done_out", cyc, result_out);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (result_out !== e.res) begin
                  n_bad++;
                  $display("FAIL result vec%0d got %h required %h", e.id, result_out, e.res);
               end
               n_vec++;
               if (cyc != e.cyc) begin
                  n_bad++;
                  $display("FAIL latency vec%0d done at cyc %0d required cyc %0d", e.id, cyc, e.cyc);
               end
            end
         end else if (result_out !== 32'h0) begin
            n_bad++;
            $display("FAIL result_idle cyc=%0d got %h required 00000000", cyc, result_out);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got %h required %h", name, act, exp);
      end
   endtask

   // Present a request for this cycle; optionally record its expected result and done cycle.
   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] res, input int lat);
      exp_t e;
      start_in = 1'b1;
      op_in    = op;
      rs1_in   = a;
      rs2_in   = b;
      if (push) begin
         vec_id++;
         e.res = res;
         e.cyc = cyc + lat;
         e.id  = vec_id;
         sb.push_back(e);
      end
   endtask

   task automatic wait_done();
      int t = 0;
      while (sb.size() != 0 && t < 80) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (sb.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL timeout %0d results still outstanding required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat);
      drive(op, a, b, 1'b1, res, lat);
      @(posedge clk);
      #1 start_in = 1'b0;
      wait_done();
   endtask

   function automatic logic [31:0] dv(input logic [31:0] x);
      return DIV_ON ? x : 32'h0;
   endfunction

   initial begin
      int          k;
      int          dl;
      int          d0;
      bit          ok;
      logic [31:0] stall_ok;
      dl       = DIV_ON ? 33 : 1;
      reset    = 1'b1;
      start_in = 1'b0;
      op_in    = 3'b000;
      rs1_in   = '0;
      rs2_in   = '0;
      flush_in = 1'b0;

      // Reset state, with a start request held to show stall_out stays low in reset
      repeat (3) @(posedge clk);
      #2 start_in = 1'b1;
      #1;
      chk("reset_stall", {31'b0, stall_out}, 32'h0);
      chk("reset_done", {31'b0, done_out}, 32'h0);
      chk("reset_result", result_out, 32'h0);
      start_in = 1'b0;

      // First start right after reset release; MUL 7 x -3 with stall window N..N+32
      @(posedge clk);
      #1 reset = 1'b0;
      k = cyc;
      drive(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 33);
      ok = 1'b1;
      @(negedge clk);
      if (stall_out !== 1'b1) ok = 1'b0;
      @(posedge clk);
      #1 start_in = 1'b0;
      for (int i = 1; i <= 33; i++) begin
         @(negedge clk);
         if (stall_out !== (i <= 32)) ok = 1'b0;
      end
      stall_ok = {31'b0, ok};
      chk("stall_window", stall_ok, 32'h1);
      wait_done();

      // Multiply vectors
      issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
      issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      issue(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33);
      issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
      issue(3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33);
      issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
      issue(3'b011, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 33);
      issue(3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33);
      issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);

      // Iterative divides (single-cycle zero results when the divider is not built)
      issue(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, dv(32'hFFFF_FFFD), dl);
      issue(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, dv(32'hFFFF_FFFF), dl);
      issue(3'b101, 32'd100, 32'd7, dv(32'd14), dl);
      issue(3'b111, 32'd100, 32'd7, dv(32'd2), dl);
      issue(3'b100, 32'd7, 32'hFFFF_FFFE, dv(32'hFFFF_FFFD), dl);
      issue(3'b110, 32'd7, 32'hFFFF_FFFE, dv(32'd1), dl);
      issue(3'b100, 32'd10, 32'd2, dv(32'd5), dl);

      // Divide special cases: always one cycle
      issue(3'b101, 32'd100, 32'd0, dv(32'hFFFF_FFFF), 1);
      issue(3'b111, 32'd100, 32'd0, dv(32'd100), 1);
      issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, dv(32'h8000_0000), 1);
      issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, dv(32'h0), 1);

      // Flush mid-MUL at N+10: idle at N+11, new start at N+11 completes at N+44
      k = cyc;
      drive(3'b000, 32'h1234_5678, 32'd3, 1'b0, 32'h0, 0);
      @(posedge clk);
      #1 start_in = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush_in = 1'b1;
      #1 chk("flush_cycle_offset", cyc - k, 32'd10);
      chk("stall_during_flush", {31'b0, stall_out}, 32'h1);
      @(posedge clk);
      #1 flush_in = 1'b0;
      #1 chk("idle_after_flush", {31'b0, stall_out}, 32'h0);
      drive(3'b000, 32'd5, 32'd6, 1'b1, 32'd30, 33);
      @(posedge clk);
      #1 start_in = 1'b0;
      wait_done();

      // Flush during DONE of a single-cycle divide suppresses done_out
      d0 = done_cnt;
      drive(3'b101, 32'd100, 32'd0, 1'b0, 32'h0, 0);
      @(posedge clk);
      #1 start_in = 1'b0;
      flush_in = 1'b1;
      @(posedge clk);
      #1 flush_in = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("done_suppressed", done_cnt - d0, 32'h0);

      // Reset asserted between edges mid-operation; outputs drop at once, op is discarded
      drive(DIV_ON ? 3'b101 : 3'b000, 32'h0000_1000, 32'd3, 1'b0, 32'h0, 0);
      @(posedge clk);
      #1 start_in = 1'b0;
      repeat (5) @(posedge clk);
      #3 chk("busy_before_reset", {31'b0, stall_out}, 32'h1);
      reset = 1'b1;
      #1;
      chk("midop_reset_stall", {31'b0, stall_out}, 32'h0);
      chk("midop_reset_done", {31'b0, done_out}, 32'h0);
      chk("midop_reset_result", result_out, 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      issue(3'b000, 32'd9, 32'd9, 32'd81, 33);

      repeat (3) @(posedge clk);
      #1 chk("scoreboard_empty", sb.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
